// File: rtl/keypad_scanner.sv
// Row-scans a 4x4 active-low keypad, debounces press and release, and encodes each
// accepted key as hex while keeping a two-digit history for the display driver.
module keypad_scanner #(
  parameter int SCAN_DIV        = 12000,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] left_digit,
  output logic [3:0] right_digit
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state_q;
  logic [3:0]    col_meta_q, col_s_q;
  logic [3:0]    row_q;
  logic [1:0]    row_idx_q, col_idx_q;
  logic [SW-1:0] scan_cnt_q;
  logic [DW-1:0] deb_cnt_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q, left_q, right_q;

  logic          single_low;
  logic [1:0]    col_idx_d, row_idx_d;
  logic [3:0]    row_rot;
  logic          key_pressed;
  logic [3:0]    key_d;

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      4'hF: k = 4'hD;
    endcase
    return k;
  endfunction

  // Columns are asynchronous to clk; only the synchronised copy is ever looked at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= col;
      col_s_q    <= col_meta_q;
    end
  end

  always_comb begin
    single_low = 1'b1;
    col_idx_d  = 2'd0;
    case (col_s_q)
      4'b1110: col_idx_d = 2'd0;
      4'b1101: col_idx_d = 2'd1;
      4'b1011: col_idx_d = 2'd2;
      4'b0111: col_idx_d = 2'd3;
      default: single_low = 1'b0;
    endcase
    row_idx_d = 2'd0;
    case (row_q)
      4'b1101: row_idx_d = 2'd1;
      4'b1011: row_idx_d = 2'd2;
      4'b0111: row_idx_d = 2'd3;
      default: row_idx_d = 2'd0;
    endcase
  end

  assign row_rot     = {row_q[2:0], row_q[3]};
  assign key_pressed = ~col_s_q[col_idx_q];
  assign key_d       = keymap(row_idx_q, col_idx_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= 4'b1110;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      left_q      <= 4'h0;
      right_q     <= 4'h0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            if (single_low) begin
              row_idx_q <= row_idx_d;
              col_idx_q <= col_idx_d;
              deb_cnt_q <= '0;
              state_q   <= DEBOUNCE;
            end else begin
              row_q <= row_rot;
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!key_pressed) begin
            row_q      <= row_rot;
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else if (deb_cnt_q == DEB_LAST) begin
            key_valid_q <= 1'b1;
            key_code_q  <= key_d;
            left_q      <= right_q;
            right_q     <= key_d;
            state_q     <= HELD;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        HELD: begin
          // Row stays frozen, so other keys cannot register until this one is released.
          if (!key_pressed) begin
            deb_cnt_q <= '0;
            state_q   <= RELEASE;
          end
        end
        RELEASE: begin
          if (key_pressed) begin
            state_q <= HELD;
          end else if (deb_cnt_q == DEB_LAST) begin
            row_q      <= row_rot;
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign row         = row_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign left_digit  = left_q;
  assign right_digit = right_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: emulated keypad matrix, cycle-level reference model, directed scenarios.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  localparam int M_SCAN = 0;
  localparam int M_PRESS = 1;
  localparam int M_HELD = 2;
  localparam int M_REL = 3;

  logic       clk;
  logic       reset;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] left_digit;
  logic [3:0] right_digit;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .reset       (reset),
    .col         (col),
    .row         (row),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .left_digit  (left_digit),
    .right_digit (right_digit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;
  int det_cyc = 0;

  logic [15:0] key_down;
  logic [3:0]  m_keys [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0]  rot_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  // Model: scan position, run length of the current column level, and digit history.
  int         m_mode, m_row, m_t, m_run, m_r, m_c;
  logic [3:0] m_h1, m_h2;
  logic [3:0] e_row, e_code, e_left, e_right;
  logic       e_kv;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SCAN; m_row = 0; m_t = 0; m_run = 0; m_r = 0; m_c = 0;
    m_h1 = 4'hF; m_h2 = 4'hF;
    e_row = 4'b1110; e_kv = 1'b0; e_code = 4'h0; e_left = 4'h0; e_right = 4'h0;
  endtask

  task automatic model_step();
    logic [3:0] cs;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    cs = m_h2;
    m_h2 = m_h1;
    m_h1 = col;
    e_kv = 1'b0;
    case (m_mode)
      M_SCAN: begin
        m_t++;
        if (m_t == SCAN_DIV) begin
          m_t = 0;
          if ($countones(~cs) == 1) begin
            for (int k = 0; k < 4; k++) if (!cs[k]) m_c = k;
            m_r = m_row; m_run = 0; m_mode = M_PRESS; det_cyc = cyc;
          end else begin
            m_row = (m_row + 1) % 4;
          end
        end
      end
      M_PRESS: begin
        if (cs[m_c]) begin
          m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_t = 0;
        end else begin
          m_run++;
          if (m_run == DEB) begin
            m_mode = M_HELD; e_kv = 1'b1;
            e_code = m_keys[m_r*4 + m_c];
            e_left = e_right;
            e_right = e_code;
          end
        end
      end
      M_HELD: begin
        if (cs[m_c]) begin
          m_mode = M_REL; m_run = 0;
        end
      end
      default: begin
        if (!cs[m_c]) begin
          m_mode = M_HELD;
        end else begin
          m_run++;
          if (m_run == DEB) begin
            m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_t = 0;
          end
        end
      end
    endcase
    e_row = 4'b1111 & ~(4'b0001 << m_row);
  endtask

  function automatic logic [3:0] keypad_col();
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int k = 0; k < 4; k++)
          if (key_down[r*4 + k]) c[k] = 1'b0;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (!reset) begin
      check("row", int'(row), int'(e_row));
      check("key_valid", int'(key_valid), int'(e_kv));
      check("key_code", int'(key_code), int'(e_code));
      check("left_digit", int'(left_digit), int'(e_left));
      check("right_digit", int'(right_digit), int'(e_right));
      if (key_valid === 1'b1) begin
        pulses++;
        pulse_cyc = cyc;
      end
    end
    #1;
    col = keypad_col();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_mode(input int m, input string name);
    int k;
    k = 0;
    while (m_mode != m && k < 200) begin
      tick();
      k++;
    end
    check(name, m_mode, m);
  endtask

  task automatic wait_pulse(input string name);
    int p0, k;
    p0 = pulses;
    k = 0;
    while (pulses == p0 && k < 120) begin
      tick();
      k++;
    end
    check(name, pulses - p0, 1);
  endtask

  initial begin
    int p0;
    col = 4'hF;
    reset = 1'b1;
    key_down = '0;
    model_reset();

    // Reset values
    run(3);
    check("rst_row", int'(row), 4'b1110);
    check("rst_kv", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_left", int'(left_digit), 0);
    check("rst_right", int'(right_digit), 0);
    reset = 1'b0;

    // Idle scan rotation
    for (int i = 0; i < 4; i++) begin
      run(SCAN_DIV);
      check("idle_rotate", int'(row), int'(rot_seq[i]));
    end
    check("idle_no_pulse", pulses, 0);

    // Key '5' held for 100 cycles
    key_down[5] = 1'b1;
    wait_mode(M_PRESS, "k5_detect");
    wait_pulse("k5_pulse");
    check("k5_latency", pulse_cyc - det_cyc, 8);
    run(100);
    check("k5_one_pulse", pulses, 1);
    check("k5_code", int'(key_code), 5);
    check("k5_right", int'(right_digit), 5);
    check("k5_left", int'(left_digit), 0);
    check("k5_row_frozen", int'(row), 4'b1101);

    // Release bounce while '5' held
    key_down[5] = 1'b0;
    run(3);
    key_down[5] = 1'b1;
    run(20);
    check("relbounce_no_pulse", pulses, 1);
    check("relbounce_held", m_mode, M_HELD);
    check("relbounce_row", int'(row), 4'b1101);

    // Other keys while '5' held
    key_down[9] = 1'b1;
    key_down[6] = 1'b1;
    run(40);
    check("rollover_no_pulse", pulses, 1);
    check("rollover_right", int'(right_digit), 5);
    key_down = '0;
    wait_mode(M_SCAN, "k5_release");
    run(10);
    check("release_no_pulse", pulses, 1);

    // Press bounce on '5': detected, then released early
    key_down[5] = 1'b1;
    wait_mode(M_PRESS, "pb_detect");
    run(3);
    key_down[5] = 1'b0;
    wait_mode(M_SCAN, "pb_abort");
    check("pb_next_row", int'(row), 4'b1011);
    run(10);
    check("pb_no_pulse", pulses, 1);

    // '1' then 'A'
    p0 = pulses;
    key_down[0] = 1'b1;
    wait_pulse("k1_pulse");
    key_down[0] = 1'b0;
    wait_mode(M_SCAN, "k1_release");
    key_down[3] = 1'b1;
    wait_pulse("kA_pulse");
    key_down[3] = 1'b0;
    wait_mode(M_SCAN, "kA_release");
    check("two_pulses", pulses - p0, 2);
    check("hist_left", int'(left_digit), 4'h1);
    check("hist_right", int'(right_digit), 4'hA);
    check("hist_code", int'(key_code), 4'hA);

    // Asynchronous reset in the middle of a debounce
    key_down[5] = 1'b1;
    wait_mode(M_PRESS, "rst_detect");
    run(2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_row", int'(row), 4'b1110);
    check("arst_left", int'(left_digit), 0);
    check("arst_right", int'(right_digit), 0);
    check("arst_code", int'(key_code), 0);
    check("arst_kv", int'(key_valid), 0);
    model_reset();
    key_down = '0;
    run(3);
    reset = 1'b0;
    run(SCAN_DIV);
    check("arst_resume_row", int'(row), 4'b1101);
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
